// File: rtl/cpu_alu_arb_pkg.sv
// Shared types and limits for the ALU arbiter.
// No logic; pure declarations.
// Not applicable: no handshakes here.
package cpu_alu_arb_pkg;

  // Response slot occupancy.
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_FULL = 1'b1
  } arb_state_t;

  // Largest requester count the picker and ID width are sized for.
  localparam int ARB_MAX_REQ = 4;

endpackage

// File: rtl/cpu_instr_pkg.sv
// Instruction field encodings (funct3 operation / funct7 modifier) shared by the ALU and its users.
// No logic; pure declarations.
// Not applicable: no handshakes here.
package cpu_instr_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;  // ADD / SUB selected by modifier
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SR   = 3'd5;  // SRL / SRA selected by modifier
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  localparam logic [6:0] MOD_BASE = 7'h00;
  localparam logic [6:0] MOD_ALT  = 7'h20;

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU: funct3 operation with funct7 modifier for ADD/SUB and SRL/SRA.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs.
module cpu_alu
  import cpu_instr_pkg::*;
(
  input  logic [2:0]  operation,
  input  logic [6:0]  mod,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        invalid_opcode
);

  logic [4:0] shamt;
  assign shamt = operand_b[4:0];

  // Decode the operation; unknown modifiers on ADD/SR flag invalid and force a zero result.
  always_comb begin
    result         = '0;
    invalid_opcode = 1'b0;
    case (operation)
      OP_ADD: begin
        if (mod == MOD_BASE)     result = operand_a + operand_b;
        else if (mod == MOD_ALT) result = operand_a - operand_b;
        else                     invalid_opcode = 1'b1;
      end
      OP_SLL:  result = operand_a << shamt;
      OP_SLT:  result = {31'b0, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: result = {31'b0, operand_a < operand_b};
      OP_XOR:  result = operand_a ^ operand_b;
      OP_SR: begin
        if (mod == MOD_BASE)     result = operand_a >> shamt;
        else if (mod == MOD_ALT) result = 32'($signed(operand_a) >>> shamt);
        else                     invalid_opcode = 1'b1;
      end
      OP_OR:   result = operand_a | operand_b;
      OP_AND:  result = operand_a & operand_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_alu_arb_rr_picker.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller gates the grant with slot availability.
module cpu_alu_arb_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;
  int   cand;

  // Walk candidates in priority order starting at rr_ptr; take the first valid one.
  always_comb begin
    found     = 1'b0;
    cand      = 0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] && (cand == j)) begin
          found     = 1'b1;
          grant_idx = ID_W'(j);
        end
      end
    end
  end

  // Expand the encoded winner to one-hot; all zero when nobody requests.
  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = found && (grant_idx == ID_W'(j));
    end
  end

endmodule

// File: rtl/cpu_alu_arbiter.sv
// Shares one cpu_alu between NUM_REQ requesters (round robin); optional counters under CPU_ALU_ARB_STATS_EN.
// Latency: accept at edge N -> registered response valid from edge N (visible during cycle N+1).
// Backpressure: a full slot with rsp_ready low drops every req_ready; consume+accept reloads with no bubble.
module cpu_alu_arbiter
  import cpu_alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [3*NUM_REQ-1:0]  req_operation,
  input  logic [7*NUM_REQ-1:0]  req_mod,
  input  logic [32*NUM_REQ-1:0] req_operand_a,
  input  logic [32*NUM_REQ-1:0] req_operand_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_invalid_opcode
`ifdef CPU_ALU_ARB_STATS_EN
  ,
  output logic [31:0]           stat_accepts,
  output logic [31:0]           stat_invalid
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_cfg
    $error("cpu_alu_arbiter: NUM_REQ must be 2..4");
  end

  arb_state_t          state_q, state_d;
  logic                live_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     rr_ptr_next;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                slot_free;
  logic                accept;

  logic [2:0]          alu_operation;
  logic [6:0]          alu_mod;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [31:0]         alu_result;
  logic                alu_invalid;

  cpu_alu_arb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // live_q keeps grants off until the first edge after reset release, so no
  // request can be accepted against a clock edge that overlaps the release.
  assign slot_free   = (state_q == ARB_IDLE) | rsp_ready;
  assign req_ready   = (live_q & slot_free) ? grant : '0;
  assign accept      = |req_ready;
  assign rsp_valid   = (state_q == ARB_FULL);
  assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Route the winning requester's slices to the shared ALU.
  always_comb begin
    alu_operation = req_operation[2:0];
    alu_mod       = req_mod[6:0];
    alu_a         = req_operand_a[31:0];
    alu_b         = req_operand_b[31:0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        alu_operation = req_operation[3*i +: 3];
        alu_mod       = req_mod[7*i +: 7];
        alu_a         = req_operand_a[32*i +: 32];
        alu_b         = req_operand_b[32*i +: 32];
      end
    end
  end

  cpu_alu u_alu (
    .operation      (alu_operation),
    .mod            (alu_mod),
    .operand_a      (alu_a),
    .operand_b      (alu_b),
    .result         (alu_result),
    .invalid_opcode (alu_invalid)
  );

  // Slot occupancy: fill on accept, empty on a consume that is not refilled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (accept) state_d = ARB_FULL;
      ARB_FULL: if (rsp_ready && !accept) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State register and post-reset grant enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Response slot and round-robin pointer load only on accept; they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result         <= '0;
      rsp_invalid_opcode <= 1'b0;
      rsp_id             <= '0;
      rr_ptr_q           <= '0;
    end else if (accept) begin
      rsp_result         <= alu_result;
      rsp_invalid_opcode <= alu_invalid;
      rsp_id             <= grant_idx;
      rr_ptr_q           <= rr_ptr_next;
    end
  end

`ifdef CPU_ALU_ARB_STATS_EN
  // Free-running accept and invalid-opcode counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_accepts <= '0;
      stat_invalid <= '0;
    end else if (accept) begin
      stat_accepts <= stat_accepts + 32'd1;
      if (alu_invalid) stat_invalid <= stat_invalid + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_alu_arbiter.sv
// Bench for cpu_alu_arbiter: 2-requester DUT against a cycle model, plus a 3-requester DUT for rotation order.
// Latency expectation: response visible the cycle after accept.
// Backpressure expectation: no req_ready while the slot is full and unconsumed.
module tb_cpu_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 2-requester DUT
  logic [1:0]  req_valid;
  wire  [1:0]  req_ready;
  logic [5:0]  req_operation;
  logic [13:0] req_mod;
  logic [63:0] req_operand_a;
  logic [63:0] req_operand_b;
  wire         rsp_valid;
  logic        rsp_ready;
  wire  [0:0]  rsp_id;
  wire  [31:0] rsp_result;
  wire         rsp_invalid_opcode;

  // 3-requester DUT
  logic [2:0]  req_valid3;
  wire  [2:0]  req_ready3;
  logic [8:0]  req_operation3;
  logic [20:0] req_mod3;
  logic [95:0] req_operand_a3;
  logic [95:0] req_operand_b3;
  wire         rsp_valid3;
  wire  [1:0]  rsp_id3;
  wire  [31:0] rsp_result3;
  wire         rsp_invalid_opcode3;

`ifdef CPU_ALU_ARB_STATS_EN
  wire [31:0] stat_accepts, stat_invalid, stat_accepts3, stat_invalid3;
`endif

  cpu_alu_arbiter #(.NUM_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operation(req_operation), .req_mod(req_mod),
    .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_invalid_opcode(rsp_invalid_opcode)
`ifdef CPU_ALU_ARB_STATS_EN
    , .stat_accepts(stat_accepts), .stat_invalid(stat_invalid)
`endif
  );

  cpu_alu_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_operation(req_operation3), .req_mod(req_mod3),
    .req_operand_a(req_operand_a3), .req_operand_b(req_operand_b3),
    .rsp_valid(rsp_valid3), .rsp_ready(1'b1), .rsp_id(rsp_id3),
    .rsp_result(rsp_result3), .rsp_invalid_opcode(rsp_invalid_opcode3)
`ifdef CPU_ALU_ARB_STATS_EN
    , .stat_accepts(stat_accepts3), .stat_invalid(stat_invalid3)
`endif
  );

  // Requesters must hold valid until accepted.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    assert property (@(posedge clk) disable iff (!rst_n)
                     (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi])
      else $error("requester %0d dropped valid before ready", gi);
  end

  // Requester intents (bench side) and reference slot model.
  bit          mv  [2];
  logic [2:0]  mop [2];
  logic [6:0]  mmd [2];
  logic [31:0] ma  [2];
  logic [31:0] mb  [2];

  bit          m_full, m_live, m_inv;
  int          m_ptr, m_id;
  logic [31:0] m_res;
  int          grant_log[$];

  int total = 0;
  int bad   = 0;

  // Reference ALU from the instruction-set meaning of each operation.
  function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [6:0] md,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh = b[4:0];
    longint sa = longint'($signed(a));
    case (op)
      3'd0: if (md == 7'h00) return {1'b0, a + b};
            else if (md == 7'h20) return {1'b0, a - b};
            else return {1'b1, 32'h0};
      3'd1: return {1'b0, 32'(64'(a) * (64'd1 << sh))};
      3'd2: return {1'b0, 32'(longint'($signed(a)) < longint'($signed(b)))};
      3'd3: return {1'b0, 32'(longint'(a) < longint'(b))};
      3'd4: return {1'b0, a ^ b};
      3'd5: if (md == 7'h00) return {1'b0, 32'(64'(a) / (64'd1 << sh))};
            else if (md == 7'h20) return {1'b0, 32'(sa >>> sh)};
            else return {1'b1, 32'h0};
      3'd6: return {1'b0, a | b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  task automatic apply();
    for (int j = 0; j < 2; j++) begin
      req_valid[j]            = mv[j];
      req_operation[3*j +: 3] = mop[j];
      req_mod[7*j +: 7]       = mmd[j];
      req_operand_a[32*j +: 32] = ma[j];
      req_operand_b[32*j +: 32] = mb[j];
    end
  endtask

  task automatic set_req(input int j, input logic [2:0] op, input logic [6:0] md,
                         input logic [31:0] a, input logic [31:0] b);
    mv[j] = 1'b1; mop[j] = op; mmd[j] = md; ma[j] = a; mb[j] = b;
  endtask

  task automatic rand_req(input int j);
    int r = $urandom_range(0, 3);
    set_req(j, 3'($urandom_range(0, 7)),
            (r == 0) ? 7'h00 : (r == 1) ? 7'h20 : 7'($urandom),
            $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom);
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance model at posedge.
  task automatic cycle();
    logic [1:0]  exp_rdy;
    logic [33:0] exp_dat;
    logic [32:0] r;
    int g = -1;
    apply();
    #1;
    if (m_live && (!m_full || rsp_ready))
      for (int k = 0; k < 2; k++)
        if (g < 0 && mv[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    total++;
    if (req_ready !== exp_rdy) begin
      bad++; $display("FAIL req_ready got=%b want=%b t=%0t", req_ready, exp_rdy, $time);
    end
    total++;
    if (rsp_valid !== m_full) begin
      bad++; $display("FAIL rsp_valid got=%b want=%b t=%0t", rsp_valid, m_full, $time);
    end
    exp_dat = {m_id[0], m_res, m_inv};
    total++;
    if ({rsp_id, rsp_result, rsp_invalid_opcode} !== exp_dat) begin
      bad++; $display("FAIL rsp_data got=%h want=%h t=%0t",
                      {rsp_id, rsp_result, rsp_invalid_opcode}, exp_dat, $time);
    end
    @(posedge clk);
    m_live = 1'b1;
    if (g >= 0) begin
      r      = alu_ref(mop[g], mmd[g], ma[g], mb[g]);
      m_inv  = r[32];
      m_res  = r[31:0];
      m_id   = g;
      m_full = 1'b1;
      m_ptr  = (g + 1) % 2;
      mv[g]  = 1'b0;
      grant_log.push_back(g);
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic wait_accept(input string name);
    int n0 = grant_log.size();
    bit got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      cycle();
      if (grant_log.size() > n0) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s_timeout got=no_accept want=accept", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) mv[j] = 1'b0;
    m_full = 0; m_live = 0; m_inv = 0; m_ptr = 0; m_id = 0; m_res = '0;
    apply();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_full = 0; m_live = 0; m_inv = 0; m_ptr = 0; m_id = 0; m_res = '0;
    set_req(0, 3'd0, 7'h00, 32'd5, 32'd7);
    set_req(1, 3'd0, 7'h20, 32'd9, 32'd4);
    apply();
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_invalid_opcode} !== 35'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
                      {rsp_valid, rsp_id, rsp_result, rsp_invalid_opcode});
    end
    total++;
    if (req_ready !== 2'b00) begin
      bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();  // first cycle after release: grants still gated
  endtask

  task automatic test_back_to_back();
    grant_log.delete();
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < 2; j++) if (!mv[j]) rand_req(j);
      cycle();
    end
    total++;
    if (grant_log.size() != 8) begin
      bad++; $display("FAIL b2b_count got=%0d want=8", grant_log.size());
    end
    for (int k = 0; k < grant_log.size(); k++) begin
      total++;
      if (grant_log[k] != k % 2) begin
        bad++; $display("FAIL b2b_order[%0d] got=%0d want=%0d", k, grant_log[k], k % 2);
      end
    end
  endtask

  task automatic test_add();
    do_reset();
    rsp_ready = 1'b1;
    cycle();
    set_req(0, 3'd0, 7'h00, 32'd5, 32'd7);
    wait_accept("add");
    total++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_invalid_opcode} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
      bad++; $display("FAIL add_rsp got=%h want=%h",
                      {rsp_valid, rsp_id, rsp_result, rsp_invalid_opcode},
                      {1'b1, 1'b0, 32'd12, 1'b0});
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    set_req(1, 3'd0, 7'h20, 32'd3, 32'd5);
    wait_accept("sub");
    rsp_ready = 1'b0;
    set_req(0, 3'd0, 7'h00, 32'd1, 32'd1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      total++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'hFFFF_FFFE}) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h want=%h", c,
                        {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b1, 32'hFFFF_FFFE});
      end
    end
    rsp_ready = 1'b1;
    cycle();
    total++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd2}) begin
      bad++; $display("FAIL bp_release got=%h want=%h",
                      {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd2});
    end
  endtask

  task automatic test_invalid();
`ifdef CPU_ALU_ARB_STATS_EN
    logic [31:0] inv0 = stat_invalid;
`endif
    rsp_ready = 1'b1;
    set_req(0, 3'd5, 7'h7F, $urandom, $urandom);
    wait_accept("inv");
    total++;
    if ({rsp_valid, rsp_invalid_opcode, rsp_result} !== {1'b1, 1'b1, 32'h0}) begin
      bad++; $display("FAIL invalid_rsp got=%h want=%h",
                      {rsp_valid, rsp_invalid_opcode, rsp_result}, {1'b1, 1'b1, 32'h0});
    end
`ifdef CPU_ALU_ARB_STATS_EN
    total++;
    if (stat_invalid !== inv0 + 32'd1) begin
      bad++; $display("FAIL stat_invalid got=%0d want=%0d", stat_invalid, inv0 + 32'd1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    set_req(0, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    wait_accept("sra");
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, rsp_result} !== {1'b1, 32'hF800_0000}) begin
      bad++; $display("FAIL sra_rsp got=%h want=%h", {rsp_valid, rsp_result}, {1'b1, 32'hF800_0000});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, rsp_result} !== 33'h0) begin
      bad++; $display("FAIL midreset_clear got=%h want=0", {rsp_valid, rsp_result});
    end
    @(negedge clk);
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 3'd4, 7'h00, 32'hF0, 32'h0F);
    set_req(1, 3'd6, 7'h00, 32'hF0, 32'h0F);
    grant_log.delete();
    wait_accept("midreset");
    total++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      bad++; $display("FAIL midreset_ptr got=%0d want=0",
                      (grant_log.size() == 0) ? -1 : grant_log[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 2; j++) if (!mv[j] && $urandom_range(0, 2) != 0) rand_req(j);
      cycle();
    end
  endtask

  task automatic test_three();
    int acc = 0;
    int prev = -1;
    int idx;
    req_valid3 = 3'b111;
    for (int j = 0; j < 3; j++) begin
      req_operation3[3*j +: 3]  = 3'd0;
      req_mod3[7*j +: 7]        = 7'h00;
      req_operand_a3[32*j +: 32] = 32'(j);
      req_operand_b3[32*j +: 32] = 32'd100;
    end
    do_reset();
    for (int c = 0; c < 40 && acc < 9; c++) begin
      #1;
      if (prev >= 0) begin
        total++;
        if ({rsp_valid3, rsp_id3, rsp_result3} !== {1'b1, 2'(prev), 32'(prev + 100)}) begin
          bad++; $display("FAIL three_rsp got=%h want=%h", {rsp_valid3, rsp_id3, rsp_result3},
                          {1'b1, 2'(prev), 32'(prev + 100)});
        end
      end
      if (acc > 0 && req_ready3 == 3'b000) begin
        total++; bad++;
        $display("FAIL three_bubble got=000 want=onehot acc=%0d", acc);
      end
      prev = -1;
      if (req_ready3 != 3'b000) begin
        idx = 0;
        for (int j = 0; j < 3; j++) if (req_ready3[j]) idx = j;
        total++;
        if ($countones(req_ready3) != 1 || idx != acc % 3) begin
          bad++; $display("FAIL three_order[%0d] got=%b want_idx=%0d", acc, req_ready3, acc % 3);
        end
        prev = idx;
        acc++;
      end
      @(negedge clk);
    end
    req_valid3 = 3'b000;
    total++;
    if (acc != 9) begin
      bad++; $display("FAIL three_timeout got=%0d want=9", acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      mv[j] = 1'b0; mop[j] = '0; mmd[j] = '0; ma[j] = '0; mb[j] = '0;
    end
    apply();
    req_valid3 = '0; req_operation3 = '0; req_mod3 = '0;
    req_operand_a3 = '0; req_operand_b3 = '0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_add();
    test_backpressure();
    test_invalid();
    test_reset_mid();
    test_random();
    test_three();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
